knot2_sig_compactor: RTL
========================

Name: knot2_sig_compactor

Overview:
- Downstream stage of the key-locked knot2 controller. Consumes its 9-bit output vector y9..y1 and compacts a programmed number of samples into a multiple-input signature register (MISR).
- Lock-evaluation benches use the signature to compare a locked instance against the oracle under a candidate key without cycle-by-cycle output comparison.
- Start/length command in; signature out with a valid/ack handshake.

Parameters:
- IN_W, 9, width of the compacted input vector; must be <= SIG_W.
- SIG_W, 16, MISR width.
- POLY, 16'h1021, feedback polynomial; the implicit x^SIG_W term is not included.
- LEN_W, 8, width of the capture-length field.

Ports:
- clk  in  1  Clock. All state updates on the posedge. The controller's outputs are stable across the posedge.
- rst  in  1  Reset. Synchronous and active-low: rst==0 at a posedge resets the block.
- start  in  1  Single-cycle command pulse; honoured only in IDLE.
- len  in  LEN_W  Number of samples to capture; sampled with start.
- seed  in  SIG_W  Initial MISR value; sampled with start.
- abort  in  1  Cancels an in-progress capture.
- y_in  in  IN_W  Controller outputs {y9..y1}, with y1 at bit 0.
- y_valid  in  1  Qualifies y_in for this cycle.
- busy  out  1  High in RUN.
- sig_valid  out  1  High in DONE.
- signature  out  SIG_W  MISR contents.
- cap_count  out  LEN_W  Number of samples captured so far in the current or last run.

Behaviour:
- Reset (rst==0 at a posedge): state=IDLE, signature=0, cap_count=0, busy=0, sig_valid=0. Reset overrides every other input, including mid-RUN and mid-DONE; no signature is emitted.
- States: IDLE, RUN, DONE; 2-bit encoding, with the type defined in the package.
- IDLE, start=1:
  - signature<=seed, cap_count<=0, remaining<=len.
  - If len==0, go to DONE (sig_valid high the next cycle, signature==seed).
  - Otherwise go to RUN.
- IDLE, start=0: hold all state.
- RUN, priority order:
  - abort=1: go to IDLE; signature and cap_count hold their current values; sig_valid never asserts.
  - y_valid=1: signature<={signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extended y_in; cap_count+=1; remaining-=1. If remaining was 1, go to DONE in the same edge.
  - y_valid=0: hold.
  - start is ignored in RUN.
- Latency: sig_valid is high in the cycle after the final accepted sample.
- DONE:
  - sig_valid=1; signature and cap_count are frozen.
  - sig_ack is not a port: the consumer acknowledges by pulsing start or abort.
  - abort=1: go to IDLE.
  - start=1: acts as ack-and-restart. Sample seed/len, then go to RUN, or back to DONE if len==0.
  - Otherwise hold indefinitely.
- y_valid is ignored outside RUN.
- Arithmetic: cap_count and remaining are LEN_W unsigned. cap_count cannot wrap because it never exceeds len. len=2^LEN_W-1 is a legal maximum.
- There is no combinational path from inputs to outputs.

Optional Feature:
- KNOT2_SIG_PARITY_EN.
- Defined: adds output sig_parity (1 bit) = XOR-reduction of the registered signature. It updates in the same cycle as signature and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package knot2_sig_pkg holds: the state enum typedef (IDLE/RUN/DONE), default POLY, IN_W=9, SIG_W=16.
- One sub-module, knot2_misr. It contains the pure register-plus-feedback slice with load, enable, load_value and data inputs.
- The top level holds the FSM and counters.

Test Plan:
- Reset mid-RUN: start len=5, 2 samples, then rst=0 -> next cycle IDLE, signature=0, cap_count=0, sig_valid=0 thereafter.
- Single sample: seed=0, len=1, y_in=9'h001 -> signature=16'h0001, cap_count=1, sig_valid high exactly one cycle after the sample.
- Feedback path: seed=16'h8000, len=1, y_in=0 -> signature=16'h1021. Then seed=0, len=2, y_in=001 then 000 -> 16'h0002.
- Gaps and handshake: len=3 with y_valid pattern 1,0,0,1,1 -> DONE after the 5th cycle. sig_valid holds 10 cycles without ack. Then a start pulse with len=0 -> DONE with signature=seed.
- Abort: abort during RUN after 1 sample, and separately abort in DONE -> IDLE, sig_valid low, no further capture. A start in RUN is ignored (cap_count continues from its value).
- Macro on: signature=16'h0003 -> sig_parity=0; 16'h0001 -> sig_parity=1.

Source files
------------

// File: rtl/knot2_sig_pkg.sv
// Shared types and default parameters for the knot2 signature compactor.
// Optional output sig_parity is enabled by defining KNOT2_SIG_PARITY_EN.
package knot2_sig_pkg;

  localparam int unsigned      DEF_IN_W  = 9;
  localparam int unsigned      DEF_SIG_W = 16;
  localparam int unsigned      DEF_LEN_W = 8;
  localparam logic [15:0]      DEF_POLY  = 16'h1021;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/knot2_misr.sv
// Multiple-input signature register: load a seed, or shift with polynomial
// feedback and fold in one input vector per enabled cycle.
module knot2_misr
  import knot2_sig_pkg::*;
#(
  parameter int unsigned       IN_W  = DEF_IN_W,
  parameter int unsigned       SIG_W = DEF_SIG_W,
  parameter logic [SIG_W-1:0]  POLY  = SIG_W'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [SIG_W-1:0] i_load_value,
  input  logic [IN_W-1:0]  i_data,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_fb;
  logic [SIG_W-1:0] w_next;

  // The x^SIG_W term is implicit: it is the bit shifted out of the MSB.
  assign w_fb   = r_sig[SIG_W-1] ? POLY : '0;
  assign w_next = {r_sig[SIG_W-2:0], 1'b0} ^ w_fb ^ SIG_W'(i_data);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sig <= '0;
    end else if (i_load) begin
      r_sig <= i_load_value;
    end else if (i_en) begin
      r_sig <= w_next;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/knot2_sig_compactor.sv
// Capture FSM and counters around knot2_misr; compacts len samples of y_in.
// Define KNOT2_SIG_PARITY_EN to add the sig_parity output.
module knot2_sig_compactor
  import knot2_sig_pkg::*;
#(
  parameter int unsigned       IN_W  = DEF_IN_W,
  parameter int unsigned       SIG_W = DEF_SIG_W,
  parameter logic [SIG_W-1:0]  POLY  = SIG_W'(DEF_POLY),
  parameter int unsigned       LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [SIG_W-1:0] seed,
  input  logic             abort,
  input  logic [IN_W-1:0]  y_in,
  input  logic             y_valid,
  output logic             busy,
  output logic             sig_valid,
  output logic [SIG_W-1:0] signature,
  output logic [LEN_W-1:0] cap_count
`ifdef KNOT2_SIG_PARITY_EN
  ,
  output logic             sig_parity
`endif
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_cap_count;
  logic             w_load;
  logic             w_en;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_en        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (y_valid) begin
          w_en = 1'b1;
          if (r_remaining == LEN_W'(1)) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // start doubles as acknowledge-and-restart; abort wins if both pulse.
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (start) begin
          w_load      = 1'b1;
          w_state_nxt = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_cap_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_remaining <= len;
        r_cap_count <= '0;
      end else if (w_en) begin
        r_remaining <= r_remaining - LEN_W'(1);
        r_cap_count <= r_cap_count + LEN_W'(1);
      end
    end
  end

  knot2_misr #(
    .IN_W  (IN_W),
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_en         (w_en),
    .i_load_value (seed),
    .i_data       (y_in),
    .o_sig        (signature)
  );

  assign busy      = (r_state == ST_RUN);
  assign sig_valid = (r_state == ST_DONE);
  assign cap_count = r_cap_count;

`ifdef KNOT2_SIG_PARITY_EN
  assign sig_parity = ^signature;
`endif

endmodule
